// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width, divider state encoding and divider latency
// used by the control unit's wait logic.
package cpu_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int DIV_LATENCY = DATA_WIDTH + 2;

    typedef enum logic [1:0] {
        DIV_IDLE  = 2'd0,
        DIV_INIT  = 2'd1,
        DIV_ITER  = 2'd2,
        DIV_FIXUP = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Multicycle signed restoring divider: one quotient bit per cycle on magnitudes,
// signs applied in FIXUP. Done reported by a one-cycle div_stop pulse.
module div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_stop,
    output logic             div_zero,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state, state_nxt;
    logic [WIDTH-1:0] dvd_r, dvs_r, dvs_mag, quo;
    logic [WIDTH:0]   rem;
    logic             q_neg, r_neg;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    // Extra top bit of trial acts as the borrow: set means shifted < |divisor|.
    assign shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign trial   = {1'b0, shifted} - {2'b0, dvs_mag};
    assign busy    = (state != DIV_IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= DIV_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE:  if (div_start) state_nxt = DIV_INIT;
            DIV_INIT:  state_nxt = (dvs_r == '0) ? DIV_IDLE : DIV_ITER;
            DIV_ITER:  if (cnt == CNT_W'(WIDTH - 1)) state_nxt = DIV_FIXUP;
            DIV_FIXUP: state_nxt = DIV_IDLE;
            default:   state_nxt = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dvd_r    <= '0;
            dvs_r    <= '0;
            dvs_mag  <= '0;
            quo      <= '0;
            rem      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            cnt      <= '0;
            hi_out   <= '0;
            lo_out   <= '0;
            div_stop <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            div_stop <= 1'b0;
            case (state)
                DIV_IDLE: begin
                    if (div_start) begin
                        dvd_r    <= dividend;
                        dvs_r    <= divisor;
                        div_zero <= 1'b0;
                    end
                end
                DIV_INIT: begin
                    if (dvs_r == '0) begin
                        div_zero <= 1'b1;
                        div_stop <= 1'b1;
                    end else begin
                        // Magnitudes are unsigned, so |INT_MIN| stays 2^(WIDTH-1).
                        quo     <= dvd_r[WIDTH-1] ? -dvd_r : dvd_r;
                        dvs_mag <= dvs_r[WIDTH-1] ? -dvs_r : dvs_r;
                        rem     <= '0;
                        q_neg   <= dvd_r[WIDTH-1] ^ dvs_r[WIDTH-1];
                        r_neg   <= dvd_r[WIDTH-1];
                        cnt     <= '0;
                    end
                end
                DIV_ITER: begin
                    if (!trial[WIDTH+1]) begin
                        rem <= trial[WIDTH:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= shifted;
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                end
                DIV_FIXUP: begin
                    lo_out   <= q_neg ? -quo : quo;
                    hi_out   <= r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    div_stop <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Randomized scoreboard bench for div_unit: stimulus pushes expected results from
// a plain-arithmetic model; a negedge monitor pops and compares on each div_stop.
module tb_div_unit;
    import cpu_pkg::*;

    localparam int W = DATA_WIDTH;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         div_start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] hi_out, lo_out;
    logic         div_stop, div_zero, busy;

    div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .div_start(div_start),
        .dividend(dividend), .divisor(divisor),
        .hi_out(hi_out), .lo_out(lo_out),
        .div_stop(div_stop), .div_zero(div_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         zero;
        int           start;
    } exp_t;

    exp_t         sb_q[$];
    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] last_lo = '0;
    logic [W-1:0] last_hi = '0;
    logic         prev_stop = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: signed division in 64-bit arithmetic, truncated to W bits.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, output exp_t e);
        longint sa, sb, q, r;
        e.start = 0;
        if (b == '0) begin
            e.lo   = last_lo;
            e.hi   = last_hi;
            e.zero = 1'b1;
        end else begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            q  = sa / sb;
            r  = sa - q * sb;
            e.lo   = q[W-1:0];
            e.hi   = r[W-1:0];
            e.zero = 1'b0;
            last_lo = e.lo;
            last_hi = e.hi;
        end
    endtask

    // Monitor: every div_stop must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t x;
        int   lat;
        if (div_stop) begin
            if (prev_stop) begin
                errors++;
                checks++;
                $display("FAIL stop_width: div_stop high for 2+ cycles at cycle %0d", cyc);
            end
            if (sb_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_stop: div_stop with no request outstanding at cycle %0d", cyc);
            end else begin
                x   = sb_q.pop_front();
                lat = cyc - x.start;
                chk("lo_out", lo_out, x.lo);
                chk("hi_out", hi_out, x.hi);
                chk("div_zero", W'(div_zero), W'(x.zero));
                chk("busy_at_stop", W'(busy), '0);
                if (x.zero) chk("zero_latency_1_or_2", W'((lat == 1) || (lat == 2)), W'(1));
                else        chk("latency", W'(lat), W'(DIV_LATENCY));
            end
        end
        prev_stop = div_stop;
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t x;
        model(a, b, x);
        div_start = 1'b1;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        #1;
        x.start   = cyc;
        div_start = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        sb_q.push_back(x);
        chk("busy_after_accept", W'(busy), W'(1));
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((sb_q.size() != 0 || busy) && n < 200);
        if (n >= 200) begin
            errors++;
            checks++;
            $display("FAIL wait_idle: timeout, %0d results outstanding, busy=%b", sb_q.size(), busy);
            sb_q.delete();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hi"}, hi_out, '0);
        chk({tag, "_lo"}, lo_out, '0);
        chk({tag, "_stop"}, W'(div_stop), '0);
        chk({tag, "_zero"}, W'(div_zero), '0);
        chk({tag, "_busy"}, W'(busy), '0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b;
        int sel;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        #1;

        issue(32'd7, 32'd2);                 wait_idle();
        issue(-32'sd7, 32'd2);               wait_idle();
        issue(32'd7, -32'sd2);               wait_idle();
        issue(32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
        issue(32'd0, 32'd5);                 wait_idle();

        // Divide by zero keeps the previous result and raises a sticky flag.
        issue(32'd7, 32'd2);                 wait_idle();
        issue(32'd5, 32'd0);                 wait_idle();
        repeat (10) @(negedge clk);
        #1;
        chk("div_zero_sticky", W'(div_zero), W'(1));
        chk("lo_held", lo_out, 32'd3);
        chk("hi_held", hi_out, 32'd1);
        issue(32'd9, 32'd3);
        chk("div_zero_cleared_on_accept", W'(div_zero), '0);
        wait_idle();

        // A start while busy must be dropped without a second div_stop.
        issue(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        #1;
        div_start = 1'b1;
        dividend  = 32'd1;
        divisor   = 32'd1;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);

        // Reset mid-operation aborts with no div_stop.
        issue(32'd100, 32'd7);
        repeat (18) @(negedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_outputs("abort");
        sb_q.delete();
        last_lo = '0;
        last_hi = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        issue(32'd8, 32'd4);                 wait_idle();

        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 7);
            a = (sel == 4) ? 32'h8000_0000 : (sel == 5) ? 32'd0 : W'($urandom);
            sel = $urandom_range(0, 7);
            case (sel)
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = W'(-$urandom_range(1, 15));
                3:       b = 32'hFFFF_FFFF;
                4:       b = 32'h8000_0000;
                default: b = W'($urandom);
            endcase
            issue(a, b);
            wait_idle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
